// File: rtl/eth_sched_pkg.sv
// Shared definitions for the Ethernet transmit scheduler: FSM encoding, source
// identifiers, the payload length type and the payload clamp helper.
package eth_sched_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic SRC_VIDEO  = 1'b0;
   localparam logic SRC_STATUS = 1'b1;

   localparam int LEN_W = 11;
   typedef logic [LEN_W-1:0] len_t;

   function automatic len_t clamp_len(input logic [31:0] value, input logic [31:0] max_payload);
      logic [31:0] c;
      c = (value > max_payload) ? max_payload : value;
      return c[LEN_W-1:0];
   endfunction

endpackage

// File: rtl/eth_sched_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module eth_sched_timer #(
   parameter int           W       = 16,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expired
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count;

   // load has priority over counting; counting stops at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/eth_tx_scheduler.sv
// Ethernet transmit scheduler: picks video or status frames, sizes and numbers them,
// and enforces the inter-frame gap. Define ETH_SCHED_FLUSH_EN to enable partial-frame flush.
module eth_tx_scheduler
   import eth_sched_pkg::*;
#(
   parameter int LVL_W        = 13,
   parameter int THRESH       = 1024,
   parameter int MAX_PAYLOAD  = 1024,
   parameter int IFG_CYCLES   = 24,
   parameter int START_TMO    = 16,
   parameter int FLUSH_CYCLES = 65535
) (
   input  logic             eth_clk,
   input  logic             rst,
   input  logic [LVL_W-1:0] fifo_level,
   input  logic             fifo_empty,
   input  logic             status_req,
   input  logic [10:0]      status_len,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic             start_send,
   output logic             src_sel,
   output logic [10:0]      frame_len,
   output logic [15:0]      frame_seq,
   output logic             status_gnt
);

   localparam logic [LVL_W-1:0] THRESH_L = LVL_W'(THRESH);
   // timer counts down to zero inclusive, so load one less than the cycle count
   localparam logic [15:0]      TMO_LOAD = 16'(START_TMO - 1);
   localparam logic [15:0]      IFG_LOAD = 16'(IFG_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic        last_src;
   logic        launch;
   logic        done;
   logic        grant_src;
   logic        tmr_load;
   logic [15:0] tmr_val;
   logic        tmr_exp;
   logic        below_thresh;
   logic        flush_exp;
   logic        vid_rdy;
   logic        stat_rdy;
   len_t        vid_len_c;
   len_t        stat_len_c;

   assign below_thresh = (fifo_level < THRESH_L);
   assign vid_rdy      = !below_thresh || (flush_exp && !fifo_empty);
   assign stat_rdy     = status_req;
   assign vid_len_c    = clamp_len(32'(fifo_level), 32'(MAX_PAYLOAD));
   assign stat_len_c   = clamp_len(32'(status_len), 32'(MAX_PAYLOAD));

   // next state, launch/complete events and shared timer reloads
   always_comb begin
      state_nx  = state;
      launch    = 1'b0;
      done      = 1'b0;
      grant_src = SRC_VIDEO;
      tmr_load  = 1'b0;
      tmr_val   = TMO_LOAD;
      case (state)
         ST_IDLE: begin
            if (vid_rdy || stat_rdy) begin
               launch    = 1'b1;
               state_nx  = ST_START;
               tmr_load  = 1'b1;
               tmr_val   = TMO_LOAD;
               grant_src = (vid_rdy && stat_rdy) ? ~last_src : stat_rdy;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_START: begin
            if (tx_busy && tx_done) begin
               done     = 1'b1;
               state_nx = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = IFG_LOAD;
            end else if (tx_busy) begin
               state_nx = ST_SEND;
            end else if (tmr_exp) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_START;
            end
         end
         ST_SEND: begin
            if (tx_done) begin
               done     = 1'b1;
               state_nx = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = IFG_LOAD;
            end else begin
               state_nx = ST_SEND;
            end
         end
         ST_GAP: begin
            if (tmr_exp) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_GAP;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   eth_sched_timer #(.W(16), .RST_VAL(16'd0)) u_phase_tmr (
      .clk      (eth_clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (1'b1),
      .expired  (tmr_exp)
   );

`ifdef ETH_SCHED_FLUSH_EN
   localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES);

   logic flush_clr;
   logic flush_cnt;

   // counts down from FLUSH_CYCLES; zero means the partial-frame deadline passed
   assign flush_clr = fifo_empty || launch;
   assign flush_cnt = (state == ST_IDLE) && !fifo_empty && below_thresh;

   eth_sched_timer #(.W(16), .RST_VAL(FLUSH_LOAD)) u_flush_tmr (
      .clk      (eth_clk),
      .rst      (rst),
      .load     (flush_clr),
      .load_val (FLUSH_LOAD),
      .dec      (flush_cnt),
      .expired  (flush_exp)
   );
`else
   assign flush_exp = 1'b0;
`endif

   // FSM state, frame descriptor and round-robin history
   always_ff @(posedge eth_clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         start_send <= 1'b0;
         status_gnt <= 1'b0;
         src_sel    <= 1'b0;
         frame_len  <= 11'd0;
         frame_seq  <= 16'd0;
         last_src   <= SRC_STATUS;
      end else begin
         state      <= state_nx;
         start_send <= launch;
         status_gnt <= launch && (grant_src == SRC_STATUS);
         if (launch) begin
            src_sel   <= grant_src;
            frame_len <= (grant_src == SRC_STATUS) ? stat_len_c : vid_len_c;
         end
         if (done) begin
            frame_seq <= frame_seq + 16'd1;
            last_src  <= src_sel;
         end
      end
   end

endmodule
